pwm_carrier_gen: RTL and testbench

Carrier generator for the PWM channel: produces the up, down or up/down counter against which the PWM comparators and dead-time stages downstream compare their duty values. It applies the clock prescaler and shadow-loads the period at selected carrier extrema. It also counts masked extremum events to raise a decimated interrupt strobe. One instance sits directly upstream of each channel's compare/dead-time logic; a master instance's sync output can realign local carriers.

---
 rtl/pwm_carrier_gen.sv | 197 +++++++++++++++++++
 tb/tb_pwm_carrier_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_gen.sv
// pwm_carrier_gen
//   Carrier generator for one PWM channel. It produces an up, down or
//   up/down counter that the downstream compare and dead-time stages use.
//   It applies an optional clock prescaler and reloads the period and mode
//   shadows at the selected carrier extrema. Selected extremum events are
//   counted so that a decimated interrupt strobe can be raised.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   carr_onoff    0 = carrier off (shadows transparent, carrier preloaded)
//   count_mode    0 none, 1 up, 2 down, 3 up/down (shadowed)
//   mask_mode     bit0 selects min events, bit1 selects max events
//   clkdiv_onoff  enables the prescaler
//   clkdiv        prescaler: one tick every clkdiv+1 cycles
//   period        carrier maximum (shadowed)
//   init_carr     start/realign value, clamped to period
//   evt_count     int_evt fires on every (evt_count+1)-th selected event
//   sync_in       one-cycle realign pulse
//   carrier       current carrier value
//   carr_dir      1 = counting up, 0 = counting down
//   evt_min/max   one-cycle pulses when a tick loads 0 / period_sh
//   upd_evt       one-cycle pulse when the shadows reload
//   int_evt       decimated interrupt pulse
//   sync_out      copy of upd_evt, feeds other instances' sync_in
module pwm_carrier_gen #(
    parameter int unsigned PWMCOUNT_WIDTH = 16,
    parameter int unsigned DIVCLK_WIDTH   = 4,
    parameter int unsigned EVTCOUNT_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      carr_onoff,
    input  logic [1:0]                count_mode,
    input  logic [1:0]                mask_mode,
    input  logic                      clkdiv_onoff,
    input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
    input  logic [PWMCOUNT_WIDTH-1:0] period,
    input  logic [PWMCOUNT_WIDTH-1:0] init_carr,
    input  logic [EVTCOUNT_WIDTH-1:0] evt_count,
    input  logic                      sync_in,
    output logic [PWMCOUNT_WIDTH-1:0] carrier,
    output logic                      carr_dir,
    output logic                      evt_min,
    output logic                      evt_max,
    output logic                      upd_evt,
    output logic                      int_evt,
    output logic                      sync_out
);

    typedef enum logic [1:0] {
        NO_COUNT     = 2'd0,
        COUNT_UP     = 2'd1,
        COUNT_DOWN   = 2'd2,
        COUNT_UPDOWN = 2'd3
    } mode_e;

    logic [PWMCOUNT_WIDTH-1:0] carrier_q, carrier_d;
    logic [PWMCOUNT_WIDTH-1:0] period_sh_q, period_sh_d;
    mode_e                     mode_sh_q, mode_sh_d;
    logic                      dir_q, dir_d;
    logic [DIVCLK_WIDTH-1:0]   presc_q, presc_d;
    logic [EVTCOUNT_WIDTH-1:0] evcnt_q, evcnt_d;
    logic                      evt_min_q, evt_min_d;
    logic                      evt_max_q, evt_max_d;
    logic                      upd_q, upd_d;
    logic                      int_q, int_d;

    logic [PWMCOUNT_WIDTH-1:0] load_val;
    logic                      load_dir;
    logic                      tick;
    logic [PWMCOUNT_WIDTH-1:0] nxt;
    logic                      nxt_dir;
    logic                      sel;

    always_comb begin
        carrier_d   = carrier_q;
        period_sh_d = period_sh_q;
        mode_sh_d   = mode_sh_q;
        dir_d       = dir_q;
        presc_d     = presc_q;
        evcnt_d     = evcnt_q;
        evt_min_d   = 1'b0;
        evt_max_d   = 1'b0;
        upd_d       = 1'b0;
        int_d       = 1'b0;
        tick        = 1'b0;
        nxt         = carrier_q;
        nxt_dir     = dir_q;
        sel         = 1'b0;

        // Preload value shared by the off state and the realign pulse.
        load_val = (init_carr > period) ? period : init_carr;
        load_dir = (mode_e'(count_mode) != COUNT_DOWN);

        if (!carr_onoff) begin
            period_sh_d = period;
            mode_sh_d   = mode_e'(count_mode);
            carrier_d   = load_val;
            dir_d       = load_dir;
            presc_d     = '0;
            evcnt_d     = '0;
        end else if (sync_in) begin
            carrier_d = load_val;
            dir_d     = load_dir;
            presc_d   = '0;
        end else begin
            if (clkdiv_onoff) begin
                // >= lets the prescaler recover when clkdiv drops below it.
                tick    = (presc_q >= clkdiv);
                presc_d = tick ? '0 : presc_q + 1'b1;
            end else begin
                tick    = 1'b1;
                presc_d = '0;
            end

            if (tick && (mode_sh_q != NO_COUNT)) begin
                case (mode_sh_q)
                    COUNT_UP: begin
                        nxt     = (carrier_q >= period_sh_q) ? '0 : carrier_q + 1'b1;
                        nxt_dir = 1'b1;
                    end
                    COUNT_DOWN: begin
                        nxt     = (carrier_q == '0) ? period_sh_q : carrier_q - 1'b1;
                        nxt_dir = 1'b0;
                    end
                    COUNT_UPDOWN: begin
                        // Direction flips on the tick that lands on an extremum.
                        if (dir_q) begin
                            nxt     = (carrier_q < period_sh_q) ? carrier_q + 1'b1 : period_sh_q;
                            nxt_dir = (nxt != period_sh_q);
                        end else begin
                            nxt     = (carrier_q != '0) ? carrier_q - 1'b1 : '0;
                            nxt_dir = (nxt == '0);
                        end
                    end
                    default: begin
                        nxt     = carrier_q;
                        nxt_dir = dir_q;
                    end
                endcase

                carrier_d = nxt;
                dir_d     = nxt_dir;
                evt_min_d = (nxt == '0);
                evt_max_d = (nxt == period_sh_q);
                sel       = (evt_min_d & mask_mode[0]) | (evt_max_d & mask_mode[1]);

                if (sel) begin
                    upd_d       = 1'b1;
                    period_sh_d = period;
                    mode_sh_d   = mode_e'(count_mode);
                    if (evcnt_q >= evt_count) begin
                        int_d   = 1'b1;
                        evcnt_d = '0;
                    end else begin
                        evcnt_d = evcnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q   <= '0;
            period_sh_q <= '0;
            mode_sh_q   <= NO_COUNT;
            dir_q       <= 1'b1;
            presc_q     <= '0;
            evcnt_q     <= '0;
            evt_min_q   <= 1'b0;
            evt_max_q   <= 1'b0;
            upd_q       <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            carrier_q   <= carrier_d;
            period_sh_q <= period_sh_d;
            mode_sh_q   <= mode_sh_d;
            dir_q       <= dir_d;
            presc_q     <= presc_d;
            evcnt_q     <= evcnt_d;
            evt_min_q   <= evt_min_d;
            evt_max_q   <= evt_max_d;
            upd_q       <= upd_d;
            int_q       <= int_d;
        end
    end

    assign carrier  = carrier_q;
    assign carr_dir = dir_q;
    assign evt_min  = evt_min_q;
    assign evt_max  = evt_max_q;
    assign upd_evt  = upd_q;
    assign int_evt  = int_q;
    assign sync_out = upd_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Directed testbench for pwm_carrier_gen.
module tb_pwm_carrier_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        carr_onoff;
    logic [1:0]  count_mode;
    logic [1:0]  mask_mode;
    logic        clkdiv_onoff;
    logic [3:0]  clkdiv;
    logic [15:0] period;
    logic [15:0] init_carr;
    logic [2:0]  evt_count;
    logic        sync_in;
    logic [15:0] carrier;
    logic        carr_dir;
    logic        evt_min;
    logic        evt_max;
    logic        upd_evt;
    logic        int_evt;
    logic        sync_out;

    int checks   = 0;
    int failures = 0;

    pwm_carrier_gen #(
        .PWMCOUNT_WIDTH(16),
        .DIVCLK_WIDTH  (4),
        .EVTCOUNT_WIDTH(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .carr_onoff  (carr_onoff),
        .count_mode  (count_mode),
        .mask_mode   (mask_mode),
        .clkdiv_onoff(clkdiv_onoff),
        .clkdiv      (clkdiv),
        .period      (period),
        .init_carr   (init_carr),
        .evt_count   (evt_count),
        .sync_in     (sync_in),
        .carrier     (carrier),
        .carr_dir    (carr_dir),
        .evt_min     (evt_min),
        .evt_max     (evt_max),
        .upd_evt     (upd_evt),
        .int_evt     (int_evt),
        .sync_out    (sync_out)
    );

    always #5 clk = ~clk;

    // Flags are packed as {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out}.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [1:0] mode, input logic [1:0] mask,
                         input logic [15:0] per, input logic [15:0] init,
                         input logic [2:0] ecnt, input logic cdiv_on,
                         input logic [3:0] cdiv);
        rst          = 1'b0;
        carr_onoff   = 1'b0;
        sync_in      = 1'b0;
        count_mode   = mode;
        mask_mode    = mask;
        period       = per;
        init_carr    = init;
        evt_count    = ecnt;
        clkdiv_onoff = cdiv_on;
        clkdiv       = cdiv;
    endtask

    task automatic test_reset();
        logic [5:0] f;
        setup(2'd1, 2'd3, 16'd9, 16'd3, 3'd0, 1'b0, 4'd0);
        carr_onoff = 1'b1;
        rst = 1'b1;
        step();
        step();
        f = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
        checks++;
        if (carrier !== 16'd0) begin
            failures++;
            $display("FAIL reset_carrier: got %0d expected 0", carrier);
        end
        checks++;
        if (f !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 100000", f);
        end
    endtask

    task automatic test_up();
        logic [15:0] ec;
        logic [5:0]  f, ef;
        setup(2'd1, 2'd2, 16'd4, 16'd0, 3'd0, 1'b0, 4'd0);
        step();
        f = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
        checks++;
        if (carrier !== 16'd0 || f !== 6'b100000) begin
            failures++;
            $display("FAIL up_off_load: got carrier=%0d flags=%b expected 0 100000", carrier, f);
        end
        carr_onoff = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            ec = 16'((i + 1) % 5);
            ef = {1'b1, ec == 0, ec == 4, ec == 4, ec == 4, ec == 4};
            f  = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
            checks++;
            if (carrier !== ec) begin
                failures++;
                $display("FAIL up_carrier step %0d: got %0d expected %0d", i, carrier, ec);
            end
            checks++;
            if (f !== ef) begin
                failures++;
                $display("FAIL up_flags step %0d: got %b expected %b", i, f, ef);
            end
        end
    endtask

    task automatic test_updown();
        int          seq_c[12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
        logic        seq_d[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
        logic [15:0] ec;
        logic [5:0]  f, ef;
        logic        ext;
        setup(2'd3, 2'd3, 16'd3, 16'd0, 3'd2, 1'b0, 4'd0);
        step();
        carr_onoff = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            ec  = 16'(seq_c[i]);
            ext = (ec == 0) || (ec == 3);
            ef  = {seq_d[i], ec == 0, ec == 3, ext, i == 8, ext};
            f   = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
            checks++;
            if (carrier !== ec) begin
                failures++;
                $display("FAIL updown_carrier step %0d: got %0d expected %0d", i, carrier, ec);
            end
            checks++;
            if (f !== ef) begin
                failures++;
                $display("FAIL updown_flags step %0d: got %b expected %b", i, f, ef);
            end
        end
    endtask

    task automatic test_down_clkdiv();
        int          seq_c[5] = '{2, 1, 0, 2, 1};
        logic [15:0] ec;
        logic [5:0]  f, ef;
        setup(2'd2, 2'd3, 16'd2, 16'd2, 3'd0, 1'b1, 4'd2);
        step();
        f = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
        checks++;
        if (carrier !== 16'd2 || f !== 6'b000000) begin
            failures++;
            $display("FAIL down_off_load: got carrier=%0d flags=%b expected 2 000000", carrier, f);
        end
        carr_onoff = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            ec = 16'(seq_c[j / 3]);
            ef = {1'b0, j == 6, j == 9, j == 6 || j == 9, j == 6 || j == 9, j == 6 || j == 9};
            f  = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
            checks++;
            if (carrier !== ec) begin
                failures++;
                $display("FAIL down_carrier cycle %0d: got %0d expected %0d", j, carrier, ec);
            end
            checks++;
            if (f !== ef) begin
                failures++;
                $display("FAIL down_flags cycle %0d: got %b expected %b", j, f, ef);
            end
        end
    endtask

    task automatic test_period_change();
        int          seq_c[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 3, 4, 5, 0};
        logic [15:0] ec;
        logic [5:0]  f, ef;
        logic        wrap;
        setup(2'd1, 2'd1, 16'd8, 16'd0, 3'd0, 1'b0, 4'd0);
        step();
        carr_onoff = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 2) period = 16'd5;
            ec   = 16'(seq_c[i]);
            wrap = (i == 8) || (i == 14);
            ef   = {1'b1, wrap, i == 7 || i == 13, wrap, wrap, wrap};
            f    = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
            checks++;
            if (carrier !== ec) begin
                failures++;
                $display("FAIL period_carrier step %0d: got %0d expected %0d", i, carrier, ec);
            end
            checks++;
            if (f !== ef) begin
                failures++;
                $display("FAIL period_flags step %0d: got %b expected %b", i, f, ef);
            end
        end
    endtask

    task automatic test_sync();
        int          seq_c[7] = '{0, 1, 2, 3, 6, 0, 1};
        logic [15:0] ec;
        logic [5:0]  f, ef;
        setup(2'd1, 2'd0, 16'd6, 16'd10, 3'd0, 1'b0, 4'd0);
        step();
        f = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
        checks++;
        if (carrier !== 16'd6 || f !== 6'b100000) begin
            failures++;
            $display("FAIL sync_off_clamp: got carrier=%0d flags=%b expected 6 100000", carrier, f);
        end
        carr_onoff = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sync_in = (i == 4);
            step();
            ec = 16'(seq_c[i]);
            ef = {1'b1, ec == 0, 1'b0, 1'b0, 1'b0, 1'b0};
            f  = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
            checks++;
            if (carrier !== ec) begin
                failures++;
                $display("FAIL sync_carrier step %0d: got %0d expected %0d", i, carrier, ec);
            end
            checks++;
            if (f !== ef) begin
                failures++;
                $display("FAIL sync_flags step %0d: got %b expected %b", i, f, ef);
            end
        end
        sync_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] f;
        setup(2'd3, 2'd0, 16'd7, 16'd0, 3'd0, 1'b0, 4'd0);
        step();
        carr_onoff = 1'b1;
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (carrier !== 16'd5 || carr_dir !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: got carrier=%0d dir=%b expected 5 0", carrier, carr_dir);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        f = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
        checks++;
        if (carrier !== 16'd0 || f !== 6'b100000) begin
            failures++;
            $display("FAIL rstmid_reset: got carrier=%0d flags=%b expected 0 100000", carrier, f);
        end
        // Shadows come out of reset as NO_COUNT, so the carrier must hold.
        for (int i = 0; i < 3; i++) begin
            step();
            f = {carr_dir, evt_min, evt_max, upd_evt, int_evt, sync_out};
            checks++;
            if (carrier !== 16'd0 || f !== 6'b100000) begin
                failures++;
                $display("FAIL rstmid_hold step %0d: got carrier=%0d flags=%b expected 0 100000",
                         i, carrier, f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_updown();
        test_down_clkdiv();
        test_period_change();
        test_sync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
